// File: rtl/step_sched_pkg.sv
// Shared types for the step scheduler: requester command encoding, scheduler states,
// and the command-count width.
package step_sched_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    CmdStepN   = 2'b00,
    CmdRestart = 2'b01,
    CmdLoop    = 2'b10,
    CmdRsvd    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/step_scheduler_if.sv
// Requester-side bus of the step scheduler: two requesters, each with command and count,
// plus grant/done/err/busy returned by the scheduler.
interface step_scheduler_if;
  import step_sched_pkg::*;

  logic [1:0]      req;
  logic [1:0]      cmd0;
  logic [1:0]      cmd1;
  logic [CntW-1:0] cnt0;
  logic [CntW-1:0] cnt1;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic            err;
  logic            busy;

  modport master (
    output req, cmd0, cmd1, cnt0, cnt1,
    input  gnt, done, err, busy
  );

  modport slave (
    input  req, cmd0, cmd1, cnt0, cnt1,
    output gnt, done, err, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves past the
// winner whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // ptr_q set means requester 1 has priority on a tie.
  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (update && (gnt != 2'b00)) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Arbitrates two requesters and sequences the external five-state step FSM through
// STEP_N / RESTART / LOOP services, reporting completion and abnormal ends.
module step_scheduler
  import step_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  step_scheduler_if.slave  bus,
  output logic             fsm_restart,
  output logic             fsm_pause,
  output logic             fsm_goto_third,
  input  logic             fsm_terminal
);

  state_e          state_q;
  cmd_e            cur_cmd_q;
  logic [CntW-1:0] rem_q;
  logic [1:0]      gnt_q;
  logic [1:0]      done_q;
  logic            err_q;

  logic [1:0]      arb_gnt;
  logic            arb_take;
  logic            in_run;
  logic            run_end;
  logic            run_err;

  assign in_run   = (state_q == StRun);
  assign arb_take = (state_q == StIdle) && (bus.req != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .update (arb_take),
    .gnt    (arb_gnt)
  );

  // Step-FSM controls depend on fsm_terminal in the same cycle, so they stay combinational.
  always_comb begin
    fsm_pause      = !(in_run && (cur_cmd_q == CmdStepN) && (rem_q != '0) && !fsm_terminal);
    fsm_restart    = in_run && (cur_cmd_q == CmdRestart);
    fsm_goto_third = in_run && (cur_cmd_q == CmdLoop) && fsm_terminal;
  end

  always_comb begin
    run_end = 1'b0;
    run_err = 1'b0;
    unique case (cur_cmd_q)
      CmdStepN: begin
        // Last advance, empty count, or early stop at the terminal state.
        run_end = (rem_q == '0) || (rem_q == CntW'(1)) || fsm_terminal;
        run_err = (rem_q != '0) && fsm_terminal;
      end
      CmdRestart: begin
        run_end = 1'b1;
      end
      CmdLoop: begin
        run_end = 1'b1;
        run_err = !fsm_terminal;
      end
      default: begin
        run_end = 1'b1;
        run_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_cmd_q <= CmdStepN;
      rem_q     <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_take) begin
            gnt_q     <= arb_gnt;
            cur_cmd_q <= arb_gnt[1] ? cmd_e'(bus.cmd1) : cmd_e'(bus.cmd0);
            rem_q     <= arb_gnt[1] ? bus.cnt1 : bus.cnt0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (!fsm_pause) begin
            rem_q <= rem_q - CntW'(1);
          end
          if (run_end) begin
            state_q <= StDone;
            done_q  <= gnt_q;
            err_q   <= run_err;
          end
        end
        StDone: begin
          gnt_q   <= 2'b00;
          state_q <= StIdle;
        end
        default: begin
          gnt_q   <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != StIdle);

endmodule
